vga_fifo_scanout: RTL and testbench
===================================

Name: vga_fifo_scanout

Overview:
Read-side consumer of the pixel async FIFO. Runs in the pixel clock domain and generates VGA raster timing (hsync/vsync/blank). Pops one FIFO word per active pixel and drives registered pixel data to the DAC/HPS VGA pins. Detects and flags underflow.

Parameters:
DATA_W, 24, pixel word width; must match the FIFO data size.
H_ACTIVE, 640, active pixels per line.
H_FP, 16, horizontal front porch in pixels.
H_SYNC, 96, hsync width in pixels.
H_BP, 48, horizontal back porch in pixels.
V_ACTIVE, 480, active lines per frame.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vsync width in lines.
V_BP, 33, vertical back porch in lines.
HS_POL, 0, hsync asserted level.
VS_POL, 0, vsync asserted level.
UF_COLOUR, 0, pixel value driven on underflow.

Ports:
clk  in  1  pixel clock; same clock as the FIFO read side.
reset  in  1  synchronous, active-high.
enable  in  1  start/continue scanout.
clear_status  in  1  clears the sticky underflow flag.
fifo_empty  in  1  FIFO empty flag.
rd_data  in  DATA_W  FIFO head word; show-ahead, valid whenever fifo_empty=0.
rd_valid  out  1  pop strobe to the FIFO.
pixel  out  DATA_W  registered pixel value.
hsync  out  1  registered horizontal sync.
vsync  out  1  registered vertical sync.
blank_n  out  1  registered; 1 = active video.
frame_start  out  1  one-cycle pulse aligned with output of pixel (0,0).
underflow  out  1  sticky underflow flag.

Behaviour:
- Counters: h_cnt runs 0..H_TOT-1, where H_TOT = sum of the H_* parameters. v_cnt runs 0..V_TOT-1 and increments when h_cnt wraps. v_cnt wraps to 0 after V_TOT-1. Counter widths are clog2 of their totals.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs_raw is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vs_raw is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- FSM states:
  - IDLE: counters held at 0; all outputs at their reset values. enable=1 moves to RUN next cycle, with counters at (0,0).
  - RUN: counters free-run.
  - STOPPING: entered from RUN when enable=0. Counters keep running until the last count of the frame (h=H_TOT-1, v=V_TOT-1), then go to IDLE. If enable returns to 1 while in STOPPING, go back to RUN with no raster disturbance.
- rd_valid is combinational: (state != IDLE) && active && !fifo_empty. At most one pop per cycle.
- Output pipeline: exactly 1 cycle of latency from counter state to outputs.
  - blank_n <= active.
  - hsync <= hs_raw ? HS_POL : ~HS_POL; vsync uses the same rule with VS_POL.
  - pixel <= active ? (fifo_empty ? UF_COLOUR : rd_data) : 0.
  - frame_start <= (state != IDLE) && h_cnt==0 && v_cnt==0.
- Underflow: active && fifo_empty in RUN/STOPPING sets underflow on the next edge.
  - No pop occurs on that cycle; the raster does not stall.
  - Pixel alignment recovery is the writer's responsibility.
- clear_status=1 clears underflow on the next edge. If a set condition occurs in the same cycle, set wins.
- Reset values (also forced in IDLE):
  - hsync=~HS_POL, vsync=~VS_POL.
  - blank_n=0, pixel=0, frame_start=0.
  - rd_valid=0, underflow=0.
  - state=IDLE, counters at 0.
- Reset asserted mid-frame: all of the above hold on the next edge; no pop occurs during or after reset until enable.
- Blanking cycles never pop, even if the FIFO is non-empty.

Test Plan:
Small raster for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOT=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOT=6); DATA_W=8.
1. FIFO preloaded with 0x01..0x0C, enable held 1.
   -> 12 rd_valid pulses per 48-cycle frame.
   -> pixel = 0x01..0x0C in order, with blank_n=1 only on those cycles.
   -> frame_start pulses once per 48 cycles.
2. Sync timing check.
   -> hsync low for output cycles of h=5,6 on every line.
   -> vsync low for the whole of line 4.
   -> otherwise both high.
3. fifo_empty=1 at pixel (2,1).
   -> pixel=UF_COLOUR on that cycle; no pop.
   -> underflow=1 next cycle and held.
   -> clear_status clears it; clear_status coincident with a new underflow leaves it at 1.
4. Drop enable mid-frame at (1,2).
   -> the frame completes; IDLE is entered after (7,5).
   -> afterwards all outputs sit at reset values and rd_valid stays 0.
   -> re-enable gives frame_start one cycle after the RUN entry.
5. Assert reset at (3,1) for 1 cycle.
   -> next cycle hsync=vsync=1, blank_n=0, pixel=0, rd_valid=0.
   -> with enable=1, scanout restarts at (0,0).
6. FIFO non-empty through blanking.
   -> rd_valid=0 for all h>=4 or v>=3 cycles.

Source files
------------

// File: rtl/vga_fifo_scanout.sv
// VGA raster generator for the pixel-clock side of the pixel FIFO: pops one word
// per active pixel and drives registered pixel/sync/blank with a sticky underflow flag.
module vga_fifo_scanout #(
    parameter int DATA_W   = 24,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter logic [DATA_W-1:0] UF_COLOUR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_status,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] pixel,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              frame_start,
    output logic              underflow
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    // Compare in one extra bit so a zero back porch cannot overflow the bounds.
    localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   H_SS_E   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   H_SE_E   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   V_SS_E   = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   V_SE_E   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t            state_reg;
    logic [HW-1:0]     h_cnt_reg;
    logic [VW-1:0]     v_cnt_reg;
    logic [DATA_W-1:0] pixel_reg;
    logic              hsync_reg;
    logic              vsync_reg;
    logic              blank_n_reg;
    logic              frame_start_reg;
    logic              underflow_reg;

    logic [HW:0] h_ext;
    logic [VW:0] v_ext;
    logic        running;
    logic        active;
    logic        hs_raw;
    logic        vs_raw;
    logic        last_count;
    logic        underflow_set;

    assign h_ext         = {1'b0, h_cnt_reg};
    assign v_ext         = {1'b0, v_cnt_reg};
    assign running       = (state_reg != IDLE);
    assign active        = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
    assign hs_raw        = (h_ext >= H_SS_E) && (h_ext < H_SE_E);
    assign vs_raw        = (v_ext >= V_SS_E) && (v_ext < V_SE_E);
    assign last_count    = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
    assign underflow_set = running && active && fifo_empty;

    // Gated by reset so a mid-frame reset can never pop the FIFO.
    assign rd_valid = !reset && running && active && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            pixel_reg       <= '0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            blank_n_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE:     if (enable) state_reg <= RUN;
                RUN:      if (!enable) state_reg <= last_count ? IDLE : STOPPING;
                STOPPING: begin
                    if (enable)          state_reg <= RUN;
                    else if (last_count) state_reg <= IDLE;
                end
                default:  state_reg <= IDLE;
            endcase

            if (running) begin
                if (h_cnt_reg == H_LAST) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
                end else begin
                    h_cnt_reg <= h_cnt_reg + 1'b1;
                end

                blank_n_reg     <= active;
                hsync_reg       <= hs_raw ? HS_POL : ~HS_POL;
                vsync_reg       <= vs_raw ? VS_POL : ~VS_POL;
                pixel_reg       <= active ? (fifo_empty ? UF_COLOUR : rd_data) : '0;
                frame_start_reg <= (h_cnt_reg == '0) && (v_cnt_reg == '0);

                // Set has priority over a simultaneous clear.
                if (underflow_set)     underflow_reg <= 1'b1;
                else if (clear_status) underflow_reg <= 1'b0;
            end else begin
                h_cnt_reg       <= '0;
                v_cnt_reg       <= '0;
                pixel_reg       <= '0;
                hsync_reg       <= ~HS_POL;
                vsync_reg       <= ~VS_POL;
                blank_n_reg     <= 1'b0;
                frame_start_reg <= 1'b0;
                underflow_reg   <= 1'b0;
            end
        end
    end

    assign pixel       = pixel_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign blank_n     = blank_n_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;
endmodule

// File: tb/tb_vga_fifo_scanout.sv
// Scoreboard bench for vga_fifo_scanout on an 8x6 raster: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_vga_fifo_scanout;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_status;
    logic       fifo_empty;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] pixel;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       frame_start;
    logic       underflow;

    vga_fifo_scanout #(
        .DATA_W(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .UF_COLOUR(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_status(clear_status),
        .fifo_empty(fifo_empty), .rd_data(rd_data), .rd_valid(rd_valid),
        .pixel(pixel), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
        logic [7:0] px;
        logic       uf;
        logic       rv;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] exp_pix[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    logic       force_empty = 1'b0;

    // Expected registered outputs plus the raster position the DUT counters hold now.
    logic       e_hs, e_vs, e_bn, e_fs, e_uf;
    logic [7:0] e_px;
    int         ch, cv;
    logic       crun;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = force_empty || (fifo_q.size() == 0);
        rd_data    = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic step();
        exp_t et;
        logic pop_now;
        logic act;
        logic [7:0] dropped;
        act = crun && (ch < 4) && (cv < 3);
        et.hs = e_hs; et.vs = e_vs; et.bn = e_bn; et.fs = e_fs;
        et.px = e_px; et.uf = e_uf;
        et.rv = !reset && act && !fifo_empty;
        exp_q.push_back(et);
        @(negedge clk);
        pop_now = rd_valid;
        @(posedge clk);
        if (reset || !crun) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_fs = 1'b0; e_px = 8'h00; e_uf = 1'b0;
            crun = !reset && enable;
            ch = 0; cv = 0;
        end else begin
            e_bn = (ch < 4) && (cv < 3);
            e_hs = !(ch == 5 || ch == 6);
            e_vs = (cv != 4);
            e_fs = (ch == 0) && (cv == 0);
            if (e_bn && !fifo_empty && exp_pix.size() > 0) e_px = exp_pix.pop_front();
            else e_px = 8'h00;
            if (e_bn && fifo_empty) e_uf = 1'b1;
            else if (clear_status)  e_uf = 1'b0;
            if (!enable && ch == 7 && cv == 5) crun = 1'b0;
            if (ch == 7) begin
                ch = 0;
                cv = (cv == 5) ? 0 : cv + 1;
            end else begin
                ch = ch + 1;
            end
        end
        #1;
        if (pop_now) begin
            pop_cnt++;
            if (fifo_q.size() > 0) dropped = fifo_q.pop_front();
        end
        fifo_refresh();
    endtask

    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        while (!(ch == h && cv == v) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_pos got=%0d,%0d expected=%0d,%0d", ch, cv, h, v);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("hsync",       32'(hsync),       32'(mon_e.hs));
            chk("vsync",       32'(vsync),       32'(mon_e.vs));
            chk("blank_n",     32'(blank_n),     32'(mon_e.bn));
            chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
            chk("pixel",       32'(pixel),       32'(mon_e.px));
            chk("underflow",   32'(underflow),   32'(mon_e.uf));
            chk("rd_valid",    32'(rd_valid),    32'(mon_e.rv));
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clear_status = 1'b0;
        fifo_refresh();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_fs = 1'b0; e_px = 8'h00; e_uf = 1'b0;
        ch = 0; cv = 0; crun = 1'b0;
        repeat (3) step();

        // Full frame from a preloaded FIFO: pixels, syncs, blanking and pop count.
        for (int i = 1; i <= 64; i++) begin
            fifo_q.push_back(8'(i));
            exp_pix.push_back(8'(i));
        end
        fifo_refresh();
        enable = 1'b1;
        step();
        pop_cnt = 0;
        repeat (48) step();
        $display("frame1: pops=%0d fifo_left=%0d", pop_cnt, fifo_q.size());
        chk("frame1_pops", 32'(pop_cnt), 32'd12);
        chk("frame1_fifo_left", 32'(fifo_q.size()), 32'd52);

        // Underflow at (2,1), then clear, then clear coincident with a new underflow.
        run_until(2, 1);
        force_empty = 1'b1; fifo_refresh();
        step();
        $display("underflow injected at (2,1)");
        force_empty = 1'b0; fifo_refresh();
        run_until(0, 2);
        clear_status = 1'b1;
        step();
        force_empty = 1'b1; fifo_refresh();
        step();
        $display("clear coincident with underflow at (1,2)");
        clear_status = 1'b0; force_empty = 1'b0; fifo_refresh();
        run_until(5, 2);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;

        // Drop enable at (1,2): frame completes, then idle, then re-enable.
        run_until(1, 2);
        enable = 1'b0;
        begin
            int n;
            n = 0;
            while (crun && n < 100) begin
                step();
                n++;
            end
            $display("stop: idle after %0d cycles", n);
        end
        repeat (10) step();
        enable = 1'b1;
        step();
        $display("re-enabled");

        // Reset for one cycle at (3,1) with enable held.
        run_until(3, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("reset pulse at (3,1)");
        repeat (60) step();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
